// File: rtl/aes_wipe_seq.sv
// AES register wipe sequencer: clears NumRegs 2-share slots with fresh PRNG words.
// Optional pre-wipe PRNG reseed is compiled in with AES_WIPE_SEQ_RESEED_EN.
module aes_wipe_seq #(
  parameter int NumRegs = 8,
  parameter int Width   = 64,
  localparam int IdxW   = $clog2(NumRegs)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wipe_req_i,
  output logic             wipe_ack_o,
  output logic             busy_o,
  output logic             prng_data_req_o,
  input  logic             prng_data_ack_i,
  input  logic [Width-1:0] prng_data0_i,
  input  logic [Width-1:0] prng_data1_i,
  output logic             prng_reseed_req_o,
  input  logic             prng_reseed_ack_i,
  output logic             wr_en_o,
  output logic [IdxW-1:0]  wr_idx_o,
  output logic [Width-1:0] wr_data0_o,
  output logic [Width-1:0] wr_data1_o
);

  // Codes are pairwise Hamming distance >= 3 so a single upset cannot
  // turn one legal state into another.
  typedef enum logic [4:0] {
    IDLE   = 5'b00000,
    RESEED = 5'b00111,
    WIPE   = 5'b11001,
    DONE   = 5'b11110
  } state_e;

  logic [4:0]       state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             wr_en_q;
  logic [IdxW-1:0]  wr_idx_q;
  logic [Width-1:0] wr_data0_q;
  logic [Width-1:0] wr_data1_q;

  logic cap;
  logic last;
  logic busy;
  logic data_req;
  logic reseed_req;
  logic wipe_ack;

  assign last = (idx_q == IdxW'(NumRegs - 1));
  assign cap  = (state_q == WIPE) && prng_data_ack_i;

`ifndef AES_WIPE_SEQ_RESEED_EN
  logic unused_reseed_ack;
  assign unused_reseed_ack = prng_reseed_ack_i;
`endif

  always_comb begin
    state_d    = IDLE;
    idx_d      = idx_q;
    busy       = 1'b1;
    data_req   = 1'b0;
    reseed_req = 1'b0;
    wipe_ack   = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy  = 1'b0;
        idx_d = '0;
        if (wipe_req_i) begin
`ifdef AES_WIPE_SEQ_RESEED_EN
          state_d = RESEED;
`else
          state_d = WIPE;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RESEED: begin
`ifdef AES_WIPE_SEQ_RESEED_EN
        reseed_req = 1'b1;
        state_d    = prng_reseed_ack_i ? WIPE : RESEED;
`else
        state_d    = IDLE;
`endif
      end
      WIPE: begin
        data_req = 1'b1;
        state_d  = WIPE;
        if (prng_data_ack_i) begin
          // Hold the index at the top slot; DONE issues its write.
          if (last) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      DONE: begin
        wipe_ack = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        busy    = 1'b1;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= '0;
      wr_data0_q <= '0;
      wr_data1_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_en_q <= cap;
      // Write data is only ever replaced by a fresh PRNG word.
      if (cap) begin
        wr_idx_q   <= idx_q;
        wr_data0_q <= prng_data0_i;
        wr_data1_q <= prng_data1_i;
      end
    end
  end

  assign wipe_ack_o      = wipe_ack;
  assign busy_o          = busy;
  assign prng_data_req_o = data_req;
`ifdef AES_WIPE_SEQ_RESEED_EN
  assign prng_reseed_req_o = reseed_req;
`else
  assign prng_reseed_req_o = 1'b0;
`endif
  assign wr_en_o         = wr_en_q;
  assign wr_idx_o        = wr_idx_q;
  assign wr_data0_o      = wr_data0_q;
  assign wr_data1_o      = wr_data1_q;

endmodule

// File: tb/tb_aes_wipe_seq.sv
// Directed bench for aes_wipe_seq (NumRegs=8, Width=64).
// Handles both the default and AES_WIPE_SEQ_RESEED_EN builds.
module tb_aes_wipe_seq;

  localparam int N = 8;
  localparam logic [63:0] B0 = 64'hA5A5A5A5A5A5A5A5;
  localparam logic [63:0] B1 = 64'h5A5A5A5A5A5A5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wack;
  logic        busy;
  logic        dreq;
  logic        dack;
  logic [63:0] d0;
  logic [63:0] d1;
  logic        rreq;
  logic        rack;
  logic        wen;
  logic [2:0]  widx;
  logic [63:0] wd0;
  logic [63:0] wd1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_wipe_seq #(.NumRegs(N), .Width(64)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .wipe_req_i        (req),
    .wipe_ack_o        (wack),
    .busy_o            (busy),
    .prng_data_req_o   (dreq),
    .prng_data_ack_i   (dack),
    .prng_data0_i      (d0),
    .prng_data1_i      (d1),
    .prng_reseed_req_o (rreq),
    .prng_reseed_ack_i (rack),
    .wr_en_o           (wen),
    .wr_idx_o          (widx),
    .wr_data0_o        (wd0),
    .wr_data1_o        (wd1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its first WIPE cycle, sampled #1 after the edge.
  task automatic start_wipe();
    req  = 1'b1;
    dack = 1'b0;
    tick();
`ifdef AES_WIPE_SEQ_RESEED_EN
    for (int i = 0; i < 3; i++) begin
      chk("rs_req", {63'd0, rreq}, 64'd1);
      chk("rs_dreq", {63'd0, dreq}, 64'd0);
      tick();
    end
    rack = 1'b1;
    chk("rs_req_ack", {63'd0, rreq}, 64'd1);
    tick();
    rack = 1'b0;
`endif
    chk("st_busy", {63'd0, busy}, 64'd1);
    chk("st_dreq", {63'd0, dreq}, 64'd1);
    chk("st_rreq", {63'd0, rreq}, 64'd0);
    chk("st_wen", {63'd0, wen}, 64'd0);
  endtask

  // One acked WIPE cycle for slot k, then check the write it produces.
  task automatic ack_slot(input int k);
    dack = 1'b1;
    d0   = B0 + 64'(k);
    d1   = B1 ^ 64'(k);
    tick();
    chk("w_en", {63'd0, wen}, 64'd1);
    chk("w_idx", {61'd0, widx}, 64'(k));
    chk("w_d0", wd0, B0 + 64'(k));
    chk("w_d1", wd1, B1 ^ 64'(k));
    chk("w_ack", {63'd0, wack}, (k == N - 1) ? 64'd1 : 64'd0);
    chk("w_busy", {63'd0, busy}, 64'd1);
  endtask

  initial begin
    rst  = 1'b1;
    req  = 1'b0;
    dack = 1'b0;
    rack = 1'b0;
    d0   = '0;
    d1   = '0;
    #1;
    chk("rst_wen", {63'd0, wen}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_dreq", {63'd0, dreq}, 64'd0);
    chk("rst_rreq", {63'd0, rreq}, 64'd0);
    chk("rst_wack", {63'd0, wack}, 64'd0);
    chk("rst_idx", {61'd0, widx}, 64'd0);
    chk("rst_wd0", wd0, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // Continuous acks, single request pulse.
    start_wipe();
    req = 1'b0;
    for (int k = 0; k < N; k++) ack_slot(k);
    dack = 1'b0;
    tick();
    chk("c_end_busy", {63'd0, busy}, 64'd0);
    chk("c_end_wen", {63'd0, wen}, 64'd0);
    chk("c_end_wack", {63'd0, wack}, 64'd0);
    chk("c_end_dreq", {63'd0, dreq}, 64'd0);
    tick();
    chk("c_stay_idle", {63'd0, busy}, 64'd0);

    // Ack pattern 1,0,0: writes only after acks, data held between them.
    start_wipe();
    req = 1'b0;
    for (int k = 0; k < N; k++) begin
      ack_slot(k);
      if (k < N - 1) begin
        for (int s = 0; s < 2; s++) begin
          dack = 1'b0;
          d0   = 64'hDEAD_BEEF_0000_0000;
          d1   = 64'h0000_0000_DEAD_BEEF;
          tick();
          chk("s_wen", {63'd0, wen}, 64'd0);
          chk("s_idx", {61'd0, widx}, 64'(k));
          chk("s_wd0", wd0, B0 + 64'(k));
          chk("s_wd1", wd1, B1 ^ 64'(k));
          chk("s_wack", {63'd0, wack}, 64'd0);
          chk("s_dreq", {63'd0, dreq}, 64'd1);
        end
      end
    end
    dack = 1'b0;
    tick();
    chk("s_end_busy", {63'd0, busy}, 64'd0);

    // Reset after the third write aborts the wipe immediately.
    start_wipe();
    req = 1'b0;
    for (int k = 0; k < 3; k++) ack_slot(k);
    dack = 1'b1;
    d0   = B0 + 64'd3;
    d1   = B1 ^ 64'd3;
    rst  = 1'b1;
    #1;
    chk("ra_wen", {63'd0, wen}, 64'd0);
    chk("ra_idx", {61'd0, widx}, 64'd0);
    chk("ra_wd0", wd0, 64'd0);
    chk("ra_wd1", wd1, 64'd0);
    chk("ra_busy", {63'd0, busy}, 64'd0);
    chk("ra_dreq", {63'd0, dreq}, 64'd0);
    chk("ra_wack", {63'd0, wack}, 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ra_post_wen", {63'd0, wen}, 64'd0);
      chk("ra_post_busy", {63'd0, busy}, 64'd0);
    end
    dack = 1'b0;

    // Held request: back-to-back wipes with one IDLE cycle between.
    start_wipe();
    for (int k = 0; k < N; k++) ack_slot(k);
    tick();
    chk("b_gap_busy", {63'd0, busy}, 64'd0);
    chk("b_gap_wen", {63'd0, wen}, 64'd0);
    chk("b_gap_wack", {63'd0, wack}, 64'd0);
    start_wipe();
    for (int k = 0; k < N; k++) ack_slot(k);
    req  = 1'b0;
    dack = 1'b0;
    tick();
    chk("b_end_busy", {63'd0, busy}, 64'd0);
    tick();
    chk("b_stay_idle", {63'd0, busy}, 64'd0);

    // Illegal state code recovers to IDLE without writing.
    dack = 1'b1;
    force dut.state_q = 5'b10101;
    #1;
    release dut.state_q;
    tick();
    chk("il_busy", {63'd0, busy}, 64'd0);
    chk("il_wen", {63'd0, wen}, 64'd0);
    chk("il_dreq", {63'd0, dreq}, 64'd0);
    dack = 1'b0;
    tick();
    chk("il_idle", {63'd0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
